uart_rx: RTL



---
 rtl/uart_pkg.sv | 15 +
 rtl/sync_2ff.sv | 25 ++
 rtl/uart_rx.sv | 127 ++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and default frame/oversample
// constants, used by the receiver, transmitter and tick generator.
package uart_pkg;

  localparam int OVERSAMPLE_DEF = 16;
  localparam int DATA_BITS_DEF  = 8;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_rx_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Generic single-bit two-flop synchroniser for asynchronous inputs.
// RST_VAL sets the value both flops take in reset (the input's idle level).
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Two-stage capture of the asynchronous input
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8N1-style deserialiser driven by a 16x (OVERSAMPLE) baud tick.
// Detects the start edge, samples every bit mid-period, checks the stop bit and
// emits a one-cycle rx_valid or frame_err pulse per frame.
//
//   state | meaning
//   IDLE  | waiting for a 1->0 edge on the synchronised line
//   START | counting half a bit to confirm the start bit
//   DATA  | sampling DATA_BITS data bits, LSB first
//   STOP  | sampling the stop bit, then report and return to IDLE
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = DATA_BITS_DEF,
  parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 baud_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);

  localparam logic [TW-1:0] T_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] T_END  = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

  uart_rx_state_e       state, state_nxt;
  logic                 rx_s, rx_q;
  logic [TW-1:0]        tcnt;
  logic [BW-1:0]        bcnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 fall_edge, mid_tick, end_tick;

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx),
    .q     (rx_s)
  );

  assign fall_edge = rx_q & ~rx_s;
  assign mid_tick  = baud_tick && (tcnt == T_MID);
  assign end_tick  = baud_tick && (tcnt == T_END);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode; a high sample at mid start bit is treated as a glitch
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (fall_edge) state_nxt = START;
      START: if (mid_tick)  state_nxt = rx_s ? IDLE : DATA;
      DATA:  if (end_tick && (bcnt == B_LAST)) state_nxt = STOP;
      STOP:  if (end_tick)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    busy = (state != IDLE);
  end

  // Datapath: edge history, tick/bit counters, shift register and result pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_q      <= 1'b1;
      tcnt      <= '0;
      bcnt      <= '0;
      shreg     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_q      <= rx_s;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (fall_edge) tcnt <= '0;
        end
        START: begin
          if (mid_tick) begin
            tcnt <= '0;
            bcnt <= '0;
          end else if (baud_tick) begin
            tcnt <= tcnt + TW'(1);
          end
        end
        DATA: begin
          if (end_tick) begin
            tcnt  <= '0;
            bcnt  <= bcnt + BW'(1);
            shreg <= {rx_s, shreg[DATA_BITS-1:1]};
          end else if (baud_tick) begin
            tcnt <= tcnt + TW'(1);
          end
        end
        STOP: begin
          if (end_tick) begin
            tcnt <= '0;
            if (rx_s) begin
              rx_data  <= shreg;
              rx_valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end else if (baud_tick) begin
            tcnt <= tcnt + TW'(1);
          end
        end
        default: tcnt <= '0;
      endcase
    end
  end

endmodule
